// File: rtl/serpent_pkg.sv
// Shared Serpent definitions: forward S-box tables, core FSM states and the
// forward linear transformation used between rounds.
package serpent_pkg;

    localparam int MAX_ROUNDS = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11, 4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
        '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10, 4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4},
        '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15, 4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2},
        '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,  4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
        '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,  4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
        '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12, 4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1},
        '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11, 4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0},
        '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11, 4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6}
    };

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Words are packed w0 in the top 32 bits down to w3 in the bottom 32 bits.
    function automatic logic [127:0] lt_fwd(input logic [127:0] b);
        logic [31:0] x0, x1, x2, x3;
        x0 = b[127:96];
        x1 = b[95:64];
        x2 = b[63:32];
        x3 = b[31:0];
        x0 = rotl32(x0, 13);
        x2 = rotl32(x2, 3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rotl32(x1, 1);
        x3 = rotl32(x3, 7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rotl32(x0, 5);
        x2 = rotl32(x2, 22);
        return {x0, x1, x2, x3};
    endfunction

endpackage

// File: rtl/serpent_sbox_fwd.sv
// Bitsliced forward substitution: 32 parallel 4-bit lookups through S-box sel,
// each slice taking bit i of every word with w0 as the least significant bit.
module serpent_sbox_fwd
    import serpent_pkg::*;
(
    input  logic [2:0]   sel,
    input  logic [127:0] data,
    output logic [127:0] result
);

    logic [3:0] nib;
    logic [3:0] sub;

    always_comb begin
        result = '0;
        nib    = '0;
        sub    = '0;
        for (int i = 0; i < 32; i++) begin
            nib = {data[i], data[32+i], data[64+i], data[96+i]};
            sub = SBOX[sel][nib];
            result[96+i] = sub[0];
            result[64+i] = sub[1];
            result[32+i] = sub[2];
            result[i]    = sub[3];
        end
    end

endmodule

// File: rtl/serpent_enc_core.sv
// Iterative Serpent encryption core: one round per clock, subkeys fetched from an
// external combinational store addressed by o_key_idx.
module serpent_enc_core
    import serpent_pkg::*;
#(
    parameter int ROUNDS = MAX_ROUNDS
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    output logic [5:0]   o_key_idx,
    input  logic [127:0] i_subkey,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [5:0] FINAL_KEY  = 6'(ROUNDS);

    state_t       state, state_next;
    logic [5:0]   round, round_next;
    logic [127:0] blk, blk_next;
    logic [127:0] keyed;
    logic [127:0] sbox_out;

    assign keyed = blk ^ i_subkey;

    serpent_sbox_fwd u_sbox (
        .sel    (round[2:0]),
        .data   (keyed),
        .result (sbox_out)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            round <= '0;
            blk   <= '0;
        end else begin
            state <= state_next;
            round <= round_next;
            blk   <= blk_next;
        end
    end

    // Outputs decode from registered state only, so reset clears them immediately.
    always_comb begin
        state_next = state;
        round_next = round;
        blk_next   = blk;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_key_idx  = '0;
        o_data     = '0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    blk_next   = i_data;
                    round_next = '0;
                    state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                o_key_idx = round;
                if (round == LAST_ROUND) begin
                    blk_next   = sbox_out;
                    state_next = ST_FINAL;
                end else begin
                    blk_next   = lt_fwd(sbox_out);
                    round_next = round + 6'd1;
                end
            end
            ST_FINAL: begin
                o_key_idx  = FINAL_KEY;
                blk_next   = keyed;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                o_valid = 1'b1;
                o_data  = blk;
                if (i_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serpent_enc_core.sv
// Scoreboard bench for serpent_enc_core: a full-round instance checked against a
// bitslice software model plus inverse round trip, and a one-round instance with hand vectors.
module tb_serpent_enc_core;

    logic         clk = 1'b0;
    logic         rst_n;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    logic         valid32, ready32, ovalid32, iready32;
    logic [127:0] data32, subkey32, odata32;
    logic [5:0]   key_idx32;

    logic         valid1, ready1, ovalid1, iready1;
    logic [127:0] data1, subkey1, odata1;
    logic [5:0]   key_idx1;

    logic [127:0] key_rom  [0:32];
    logic [127:0] key1_rom [0:1];

    logic [127:0] exp_q[$];
    logic [127:0] pt_q[$];
    int           acc_q[$];
    logic [127:0] exp1_q[$];
    int           acc1_q[$];
    bit           seen32 = 0;
    bit           seen1 = 0;

    // Forward S-boxes as 64-bit strings, entry 0 in the top nibble.
    logic [63:0] sbox_tab [8] = '{
        64'h38F1A65BED42709C, 64'hFC27905A1BE86D34, 64'h86793CAFD1E40B52, 64'h0FB8C963D124A75E,
        64'h1F83C0B6254A9E7D, 64'hF52B4A9C03E8D671, 64'h72C5846BE91FD3A0, 64'h1DF0E82B74CA9356
    };

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign subkey32 = key_rom[key_idx32];
    assign subkey1  = key1_rom[key_idx1[0]];

    serpent_enc_core #(.ROUNDS(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid32), .o_ready(ready32),
        .i_data(data32), .o_key_idx(key_idx32), .i_subkey(subkey32),
        .o_valid(ovalid32), .i_ready(iready32), .o_data(odata32)
    );

    serpent_enc_core #(.ROUNDS(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid1), .o_ready(ready1),
        .i_data(data1), .o_key_idx(key_idx1), .i_subkey(subkey1),
        .o_valid(ovalid1), .i_ready(iready1), .o_data(odata1)
    );

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        logic [63:0] t;
        t = {v, v};
        return t[63-n -: 32];
    endfunction

    function automatic logic [3:0] sbox_val(input int s, input int x);
        logic [63:0] t;
        t = sbox_tab[s];
        return t[63-4*x -: 4];
    endfunction

    function automatic logic [127:0] sub_model(input logic [127:0] b, input int s, input bit inv);
        logic [127:0] o;
        logic [3:0]   x, y;
        o = '0;
        for (int i = 0; i < 32; i++) begin
            x = {b[i], b[32+i], b[64+i], b[96+i]};
            y = '0;
            if (!inv) y = sbox_val(s, int'(x));
            else for (int j = 0; j < 16; j++) if (sbox_val(s, j) == x) y = 4'(j);
            o[96+i] = y[0];
            o[64+i] = y[1];
            o[32+i] = y[2];
            o[i]    = y[3];
        end
        return o;
    endfunction

    function automatic logic [127:0] lt_model(input logic [127:0] b, input bit inv);
        logic [31:0] x0, x1, x2, x3;
        {x0, x1, x2, x3} = b;
        if (!inv) begin
            x0 = rol(x0, 13); x2 = rol(x2, 3);
            x1 = x1 ^ x0 ^ x2; x3 = x3 ^ x2 ^ (x0 << 3);
            x1 = rol(x1, 1); x3 = rol(x3, 7);
            x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7);
            x0 = rol(x0, 5); x2 = rol(x2, 22);
        end else begin
            x2 = rol(x2, 10); x0 = rol(x0, 27);
            x2 = x2 ^ x3 ^ (x1 << 7); x0 = x0 ^ x1 ^ x3;
            x3 = rol(x3, 25); x1 = rol(x1, 31);
            x3 = x3 ^ x2 ^ (x0 << 3); x1 = x1 ^ x0 ^ x2;
            x2 = rol(x2, 29); x0 = rol(x0, 19);
        end
        return {x0, x1, x2, x3};
    endfunction

    function automatic logic [127:0] enc_model(input logic [127:0] pt);
        logic [127:0] b;
        b = pt;
        for (int r = 0; r < 32; r++) begin
            b = sub_model(b ^ key_rom[r], r % 8, 1'b0);
            if (r < 31) b = lt_model(b, 1'b0);
        end
        return b ^ key_rom[32];
    endfunction

    function automatic logic [127:0] dec_model(input logic [127:0] ct);
        logic [127:0] b;
        b = ct ^ key_rom[32];
        b = sub_model(b, 7, 1'b1) ^ key_rom[31];
        for (int r = 30; r >= 0; r--) begin
            b = lt_model(b, 1'b1);
            b = sub_model(b, r % 8, 1'b1) ^ key_rom[r];
        end
        return b;
    endfunction

    // Monitors: latency on first o_valid, data and round trip on the handshake.
    always @(negedge clk) begin
        if (rst_n && ovalid32) begin
            if (!seen32) begin
                seen32 = 1;
                if (acc_q.size() == 0) check_output("unexpected_valid32", 128'(ovalid32), 128'd0);
                else check_output("latency32", 128'((cyc + 1) - acc_q.pop_front()), 128'd34);
            end
            if (iready32) begin
                seen32 = 0;
                if (exp_q.size() == 0) begin
                    check_output("unexpected_out32", odata32, 128'd0);
                end else begin
                    check_output("ciphertext32", odata32, exp_q.pop_front());
                    check_output("round_trip32", dec_model(odata32), pt_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ovalid1) begin
            if (!seen1) begin
                seen1 = 1;
                if (acc1_q.size() == 0) check_output("unexpected_valid1", 128'(ovalid1), 128'd0);
                else check_output("latency1", 128'((cyc + 1) - acc1_q.pop_front()), 128'd3);
            end
            if (iready1) begin
                seen1 = 0;
                if (exp1_q.size() == 0) check_output("unexpected_out1", odata1, 128'd0);
                else check_output("ciphertext1", odata1, exp1_q.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input bit use_small, input logic [127:0] pt, input logic [127:0] exp);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!(use_small ? ready1 : ready32) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            check_output("ready_timeout", 128'd0, 128'd1);
            return;
        end
        if (use_small) begin
            data1 = pt; valid1 = 1'b1;
            exp1_q.push_back(exp); acc1_q.push_back(cyc + 1);
        end else begin
            data32 = pt; valid32 = 1'b1;
            exp_q.push_back(exp); pt_q.push_back(pt); acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        valid32 = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) check_output("drain_timeout", 128'd0, 128'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] pt, held;
        int budget;
        rst_n = 1'b0;
        valid32 = 1'b0; data32 = '0; iready32 = 1'b1;
        valid1 = 1'b0;  data1 = '0;  iready1 = 1'b1;
        for (int k = 0; k <= 32; k++) key_rom[k] = '0;
        key1_rom[0] = '0; key1_rom[1] = '0;

        #13;
        check_output("reset_valid", 128'(ovalid32), 128'd0);
        check_output("reset_data", odata32, 128'd0);
        check_output("reset_key_idx", 128'(key_idx32), 128'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check_output("ready_after_reset", 128'(ready32), 128'd1);

        // Zero keys and plaintext: key index walks 0..32 after the accept edge.
        apply_stimulus(1'b0, '0, enc_model('0));
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            check_output($sformatf("key_idx_%0d", k), 128'(key_idx32), 128'(k));
        end
        @(negedge clk);
        check_output("key_idx_done", 128'(key_idx32), 128'd0);
        drain();

        for (int k = 0; k <= 32; k++)
            key_rom[k] = {32'h9E3779B9 * 32'(k + 1), 32'h01234567 ^ 32'(k), 32'hDEADBEEF + 32'(k), 32'(k) << 8};
        apply_stimulus(1'b0, 128'h00112233_44556677_8899AABB_CCDDEEFF, enc_model(128'h00112233_44556677_8899AABB_CCDDEEFF));
        apply_stimulus(1'b0, '1, enc_model('1));
        apply_stimulus(1'b0, 128'h80000000_00000000_00000000_00000001, enc_model(128'h80000000_00000000_00000000_00000001));
        drain();

        // Output held with downstream stalled; a stray i_valid must be ignored.
        iready32 = 1'b0;
        apply_stimulus(1'b0, 128'hCAFEF00D_12345678_0F0F0F0F_A5A5A5A5, enc_model(128'hCAFEF00D_12345678_0F0F0F0F_A5A5A5A5));
        budget = 0;
        while (!ovalid32 && budget < 100) begin @(negedge clk); budget++; end
        check_output("hold_valid_seen", 128'(ovalid32), 128'd1);
        held = odata32;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            valid32 = (c == 3);
            data32 = '1;
            @(negedge clk);
            check_output("hold_data", odata32, held);
            check_output("hold_ready", 128'(ready32), 128'd0);
        end
        @(posedge clk); #1;
        valid32 = 1'b0;
        iready32 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("release_ready", 128'(ready32), 128'd1);
        check_output("release_valid", 128'(ovalid32), 128'd0);
        drain();

        // Asynchronous abort in the middle of a block.
        apply_stimulus(1'b0, 128'h13579BDF_2468ACE0_FFFF0000_0000FFFF, enc_model(128'h13579BDF_2468ACE0_FFFF0000_0000FFFF));
        budget = 0;
        while (key_idx32 != 6'd15 && budget < 50) begin @(negedge clk); budget++; end
        check_output("abort_round", 128'(key_idx32), 128'd15);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort_valid", 128'(ovalid32), 128'd0);
        check_output("abort_data", odata32, 128'd0);
        check_output("abort_key_idx", 128'(key_idx32), 128'd0);
        check_output("abort_ready", 128'(ready32), 128'd1);
        void'(exp_q.pop_back()); void'(pt_q.pop_back()); void'(acc_q.pop_back());
        @(negedge clk); #2 rst_n = 1'b1;
        apply_stimulus(1'b0, 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE, enc_model(128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE));
        drain();

        // One-round instance, hand-derived from S0.
        apply_stimulus(1'b1, '0, 128'hFFFFFFFF_FFFFFFFF_00000000_00000000);
        apply_stimulus(1'b1, '1, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF);
        apply_stimulus(1'b1, 128'h0000000F_00000000_00000000_00000000, 128'hFFFFFFF0_FFFFFFF0_00000000_0000000F);
        drain();
        key1_rom[1] = 128'h00000001_00000002_00000003_00000004;
        apply_stimulus(1'b1, '0, 128'hFFFFFFFE_FFFFFFFD_00000003_00000004);
        drain();
        key1_rom[0] = 128'hFFFFFFFF_00000000_00000000_00000000;
        key1_rom[1] = '0;
        apply_stimulus(1'b1, '0, 128'h00000000_00000000_00000000_FFFFFFFF);
        drain();

        // Random round trip with fresh subkeys.
        for (int k = 0; k <= 32; k++) key_rom[k] = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 0; n < 100; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            apply_stimulus(1'b0, pt, enc_model(pt));
        end
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serpent_enc_core.md
SERPENT_ENC_CORE -- requirements
Module: serpent_enc_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, number of Serpent rounds; legal range 1..32, where values below 32 are for reduced-round test only.
REQ-002 SHALL have i_clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-003 SHALL have i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have i_valid, input, 1, plaintext valid.
REQ-005 SHALL have o_ready, output, 1, core can accept plaintext.
REQ-006 SHALL have i_data, input, 128, plaintext; word w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0].
REQ-007 SHALL have o_key_idx, output, 6, subkey index requested (0..ROUNDS).
REQ-008 SHALL have i_subkey, input, 128, subkey K[o_key_idx], valid in the same cycle (combinational lookup), same word order as i_data.
REQ-009 SHALL have o_valid, output, 1, ciphertext valid.
REQ-010 SHALL have i_ready, input, 1, downstream accepts ciphertext.
REQ-011 SHALL have o_data, output, 128, ciphertext, same word order as i_data.

Function
REQ-012 SHALL implement an FSM with states IDLE, ROUND, FINAL and DONE.
REQ-013 IDLE: o_ready=1; when i_valid=1, SHALL load state register B from i_data, clear round counter r to 0, and go to ROUND.
REQ-014 ROUND: o_key_idx=r; SHALL form each 4-bit slice for bit i=0..31 as {w3[i],w2[i],w1[i],w0[i]} of (B xor i_subkey) and apply forward S-box S[r mod 8].
REQ-015 ROUND with r<ROUNDS-1: SHALL set B = LT(S-box output) and increment r.
REQ-016 ROUND with r=ROUNDS-1: SHALL set B = S-box output with no LT, and go to FINAL.
REQ-017 LT on words X0..X3, in this order: X0<<<13; X2<<<3; X1^=X0^X2; X3^=X2^(X0<<3); X1<<<1; X3<<<7; X0^=X1^X3; X2^=X3^(X1<<7); X0<<<5; X2<<<22. Here <<< is 32-bit rotate left and << is logical shift left.
REQ-018 FINAL: o_key_idx=ROUNDS; SHALL set B = B xor i_subkey and go to DONE.
REQ-019 DONE: o_valid=1 and o_data=B; when i_ready=1, SHALL go to IDLE; o_data SHALL remain stable while o_valid=1 and i_ready=0.
REQ-020 SHALL have latency ROUNDS+2 cycles from the accept edge to o_valid=1 (34 for ROUNDS=32); back-to-back throughput is one block per ROUNDS+3 cycles minimum.
REQ-021 o_ready SHALL be 0 in every state except IDLE, and i_valid SHALL be ignored outside IDLE.
REQ-022 The o_valid to IDLE transition SHALL NOT accept new plaintext in the same cycle; acceptance occurs on the next IDLE cycle.
REQ-023 o_key_idx SHALL be 0 in IDLE and DONE.
REQ-024 i_subkey SHALL be ignored in IDLE and DONE.

Reset
REQ-025 When i_rst_n=0, SHALL immediately force: state IDLE, r=0, B=0, o_valid=0, o_data=0, o_key_idx=0.
REQ-026 Reset asserted mid-operation (ROUND, FINAL or DONE) SHALL abort the block with no ciphertext emitted.
REQ-027 o_ready SHALL be 1 from the first clock edge after i_rst_n deasserts.

Structure
REQ-028 serpent_pkg SHALL hold the eight forward S-box tables, with S0 = 3 8 15 1 10 6 5 11 14 13 4 2 7 0 9 12 and S1..S7 per the Serpent specification, the FSM state typedef, and the constant MAX_ROUNDS=32.
REQ-029 The 32-slice forward substitution SHALL be one combinational sub-module, serpent_sbox_fwd (128-bit data, 3-bit S-box index), instantiated once.
REQ-030 The LT SHALL be implemented as a function in serpent_pkg.

Verification
REQ-031 Zero subkeys, plaintext 0, ROUNDS=32: the accept edge shall be followed by o_key_idx stepping 0,1,...,32 one per cycle, o_valid=1 exactly 34 cycles later, and o_data equal to the software bitslice reference model.
REQ-032 Serpent-128 known-answer vector (expanded K0..K32 served from a bench ROM): o_data shall equal the published ciphertext.
REQ-033 o_valid held with i_ready=0 for 10 cycles: o_data stable, o_ready=0, a pulsed i_valid ignored; then i_ready=1 gives IDLE next cycle and o_ready=1.
REQ-034 i_rst_n pulsed low at round 15: outputs zero asynchronously, no o_valid; a subsequent block completes correctly.
REQ-035 ROUNDS=1, plaintext 0, all subkeys 0: o_data shall equal the S0 result for slice 0, i.e. every slice {w3,w2,w1,w0}=0011, giving w0=w1=FFFFFFFF and w2=w3=0, after a 3-cycle latency.
REQ-036 Round-trip: the ciphertext, decrypted by the team's inverse S-box and inverse-LT path with the same subkeys, shall reproduce 100 random plaintexts.
